// File: rtl/cwe1280_pkg.sv
// Shared types and constants for the protected-register access arbiter.
package cwe1280_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam logic [2:0]  AUTH_ID_DEFAULT = 3'h4;
    localparam int unsigned CNT_W           = 8;
    localparam logic [7:0]  CNT_MAX         = 8'hFF;

    // Index width that stays legal for a single requester.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cwe1280_rr_arb.sv
// Round-robin selector: first asserted request at or after the pointer.
module cwe1280_rr_arb
    import cwe1280_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    localparam int unsigned IDX_W  = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   winner,
    output logic               valid
);

    int unsigned idx;

    always_comb begin
        winner = '0;
        valid  = 1'b0;
        idx    = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = 32'(ptr) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!valid && req[IDX_W'(idx)]) begin
                valid  = 1'b1;
                winner = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/cwe1280_access_arbiter.sv
// Arbitrated write port to a protected register; only AUTH_ID may commit.
module cwe1280_access_arbiter
    import cwe1280_pkg::*;
#(
    parameter int unsigned     NUM_REQ = 4,
    parameter int unsigned     DATA_W  = 8,
    parameter int unsigned     ID_W    = 3,
    parameter logic [ID_W-1:0] AUTH_ID = ID_W'(AUTH_ID_DEFAULT)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ID_W-1:0]   usr_id,
    input  logic [NUM_REQ*DATA_W-1:0] data_in,
    output logic [NUM_REQ-1:0]        ack,
    output logic [NUM_REQ-1:0]        deny,
    output logic [DATA_W-1:0]         data_out,
    output logic                      busy,
    output logic [CNT_W-1:0]          viol_cnt,
    output logic                      violation
);

    localparam int unsigned IDX_W = idx_width(NUM_REQ);

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [IDX_W-1:0]    lat_idx_q, lat_idx_d;
    logic [ID_W-1:0]     lat_id_q, lat_id_d;
    logic [DATA_W-1:0]   lat_data_q, lat_data_d;
    logic [DATA_W-1:0]   data_d;
    logic [NUM_REQ-1:0]  ack_d, deny_d;
    logic [CNT_W-1:0]    cnt_d;
    logic                viol_d;
    logic                busy_d;

    logic [IDX_W-1:0]    arb_idx;
    logic                arb_valid;
    logic [ID_W-1:0]     id_arr   [NUM_REQ];
    logic [DATA_W-1:0]   data_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign id_arr[g]   = usr_id[g*ID_W +: ID_W];
        assign data_arr[g] = data_in[g*DATA_W +: DATA_W];
    end

    cwe1280_rr_arb #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arb (
        .req    (req),
        .ptr    (ptr_q),
        .winner (arb_idx),
        .valid  (arb_valid)
    );

    // Next-state and next-output logic; the ID check gates any register update.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        lat_idx_d  = lat_idx_q;
        lat_id_d   = lat_id_q;
        lat_data_d = lat_data_q;
        data_d     = data_out;
        ack_d      = '0;
        deny_d     = '0;
        cnt_d      = viol_cnt;
        viol_d     = violation;

        case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    lat_idx_d  = arb_idx;
                    lat_id_d   = id_arr[arb_idx];
                    lat_data_d = data_arr[arb_idx];
                    state_d    = CHECK;
                end
            end
            CHECK: begin
                if (lat_id_q == AUTH_ID) begin
                    data_d           = lat_data_q;
                    ack_d[lat_idx_q] = 1'b1;
                end else begin
                    deny_d[lat_idx_q] = 1'b1;
                    viol_d            = 1'b1;
                    if (viol_cnt != CNT_MAX) begin
                        cnt_d = viol_cnt + CNT_W'(1);
                    end
                end
                ptr_d   = (lat_idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : lat_idx_q + IDX_W'(1);
                state_d = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            lat_idx_q  <= '0;
            lat_id_q   <= '0;
            lat_data_q <= '0;
            data_out   <= '0;
            ack        <= '0;
            deny       <= '0;
            busy       <= 1'b0;
            viol_cnt   <= '0;
            violation  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            lat_idx_q  <= lat_idx_d;
            lat_id_q   <= lat_id_d;
            lat_data_q <= lat_data_d;
            data_out   <= data_d;
            ack        <= ack_d;
            deny       <= deny_d;
            busy       <= busy_d;
            viol_cnt   <= cnt_d;
            violation  <= viol_d;
        end
    end

endmodule

// File: tb/tb_cwe1280_access_arbiter.sv
// Scoreboard bench for cwe1280_access_arbiter with a transaction-level reference model.
module tb_cwe1280_access_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int IW = 3;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req;
    logic [N*IW-1:0] usr_id;
    logic [N*DW-1:0] data_in;
    logic [N-1:0]    ack, deny;
    logic [DW-1:0]   data_out;
    logic            busy;
    logic [7:0]      viol_cnt;
    logic            violation;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int         idx;
        bit         ok;
        logic [7:0] data;
        logic [7:0] cnt;
        bit         viol;
    } exp_t;

    exp_t       exp_q[$];
    int         m_ptr;
    logic [7:0] m_data, m_cnt;
    bit         m_viol;
    logic [7:0] cur_data;

    cwe1280_access_arbiter #(
        .NUM_REQ (N),
        .DATA_W  (DW),
        .ID_W    (IW),
        .AUTH_ID (3'h4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .usr_id    (usr_id),
        .data_in   (data_in),
        .ack       (ack),
        .deny      (deny),
        .data_out  (data_out),
        .busy      (busy),
        .viol_cnt  (viol_cnt),
        .violation (violation)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, want);
        end
    endtask

    task automatic set_req(input int i, input logic [2:0] id, input logic [7:0] d);
        usr_id[i*IW +: IW]  = id;
        data_in[i*DW +: DW] = d;
    endtask

    // Reference: one completed transaction for requester i, using its current inputs.
    task automatic model_push(input int i);
        exp_t e;
        e.idx = i;
        e.ok  = (usr_id[i*IW +: IW] == 3'h4);
        if (e.ok) begin
            m_data = data_in[i*DW +: DW];
        end else begin
            if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
            m_viol = 1'b1;
        end
        e.data = m_data;
        e.cnt  = m_cnt;
        e.viol = m_viol;
        m_ptr  = (i + 1) % N;
        exp_q.push_back(e);
    endtask

    task automatic model_reset();
        m_ptr    = 0;
        m_data   = 8'h00;
        m_cnt    = 8'h00;
        m_viol   = 1'b0;
        cur_data = 8'h00;
        exp_q.delete();
    endtask

    // Raise a set of held requests together; each drops once answered.
    task automatic run_batch(input logic [N-1:0] mask);
        logic [N-1:0] pend;
        int first;
        int it;
        pend  = mask;
        first = 0;
        it    = 0;
        while (pend != 0) begin
            int w;
            w = -1;
            for (int k = 0; k < N; k++) begin
                int j;
                j = (m_ptr + k) % N;
                if (w < 0 && ((pend >> j) & 1) != 0) w = j;
            end
            pend = pend & ~(N'(1) << w);
            model_push(w);
        end
        req = mask;
        while ((req != 0 || busy) && it < 64) begin
            @(negedge clk);
            it++;
            if ((ack | deny) != 0 && first == 0) first = it;
            req = req & ~(ack | deny);
        end
        check("batch_complete", 32'(it < 64), 1);
        if ($countones(mask) == 1) check("latency", first, 2);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_data_out", data_out, 0);
        check("rst_ack", ack, 0);
        check("rst_deny", deny, 0);
        check("rst_busy", busy, 0);
        check("rst_viol_cnt", viol_cnt, 0);
        check("rst_violation", violation, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: pops the scoreboard on every response, checks hold and exclusivity otherwise.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                check("onehot_resp", 32'($onehot0(ack | deny) && ((ack & deny) == 0)), 1);
                if ((ack | deny) != 0) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_resp", {ack, deny}, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("ack", ack, e.ok ? (1 << e.idx) : 0);
                        check("deny", deny, e.ok ? 0 : (1 << e.idx));
                        check("data_out", data_out, e.data);
                        check("viol_cnt", viol_cnt, e.cnt);
                        check("violation", violation, e.viol);
                        cur_data = e.data;
                    end
                end else begin
                    check("data_hold", data_out, cur_data);
                end
            end
        end
    end

    initial begin
        req     = '0;
        usr_id  = '0;
        data_in = '0;
        model_reset();
        do_reset();

        set_req(0, 3'h4, 8'hAB);
        run_batch(4'b0001);
        check("t1_data", data_out, 8'hAB);
        check("t1_cnt", viol_cnt, 0);

        set_req(1, 3'h3, 8'hCD);
        run_batch(4'b0010);
        check("t2_data", data_out, 8'hAB);
        check("t2_cnt", viol_cnt, 1);
        check("t2_viol", violation, 1);

        do_reset();
        for (int i = 0; i < N; i++) set_req(i, 3'h4, 8'(8'h10 + i));
        run_batch(4'b1111);
        check("t3_data", data_out, 8'h13);
        set_req(0, 3'h4, 8'h20);
        run_batch(4'b0001);
        check("t3_wrap", data_out, 8'h20);

        set_req(0, 3'h4, 8'h55);
        model_push(0);
        req = 4'b0001;
        @(negedge clk);
        set_req(0, 3'h3, 8'h66);
        req = 4'b0000;
        for (int it = 0; it < 16 && busy; it++) @(negedge clk);
        check("t5_idle", busy, 0);
        check("t5_data", data_out, 8'h55);

        for (int r = 0; r < 300; r++) begin
            set_req(2, 3'h3, 8'($urandom));
            run_batch(4'b0100);
        end
        check("t4_sat", viol_cnt, 8'hFF);
        check("t4_data", data_out, 8'h55);

        for (int b = 0; b < 40; b++) begin
            for (int i = 0; i < N; i++)
                set_req(i, ($urandom_range(0, 1) != 0) ? 3'h4 : 3'($urandom_range(0, 7)), 8'($urandom));
            run_batch(4'($urandom_range(1, 15)));
        end

        set_req(0, 3'h4, 8'h5A);
        run_batch(4'b0001);
        set_req(0, 3'h4, 8'h77);
        req = 4'b0001;
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        #1;
        check("t6_data", data_out, 0);
        check("t6_ack", ack, 0);
        check("t6_busy", busy, 0);
        check("t6_cnt", viol_cnt, 0);
        req = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("t6_idle", busy, 0);
        check("t6_nowrite", data_out, 0);

        set_req(3, 3'h4, 8'h99);
        run_batch(4'b1000);
        check("t7_data", data_out, 8'h99);

        repeat (4) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
